mul_arbiter: RTL and testbench



---
 rtl/mdu_pkg.sv | 18 +
 rtl/mul_arbiter_if.sv | 44 ++++
 rtl/rr_arb2.sv | 25 ++
 rtl/mul_arbiter.sv | 91 +++++++++
 tb/tb_mul_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared multiply-unit definitions: RISC-V M-extension multiply types and requester indexing.
package mdu_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t MUL    = 3'b000;
  localparam funct3_t MULH   = 3'b001;
  localparam funct3_t MULHSU = 3'b010;
  localparam funct3_t MULHU  = 3'b011;

  // Index of one of the two requesters sharing the multiplier.
  typedef logic req_idx_t;

  function automatic logic [1:0] onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared multiplier arbiter.
interface mul_arbiter_if #(
  parameter int XLEN = 64,
  parameter int CNTW = 16
);

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [XLEN-1:0]      req_a0;
  logic [XLEN-1:0]      req_b0;
  logic [XLEN-1:0]      req_a1;
  logic [XLEN-1:0]      req_b1;
  logic [1:0][2:0]      req_funct3;
  logic [1:0]           flush;

  logic [XLEN-1:0]      mul_src_a_e;
  logic [XLEN-1:0]      mul_src_b_e;
  logic [2:0]           mul_funct3_e;
  logic                 mul_stall_m;
  logic                 mul_flush_m;
  logic [2*XLEN-1:0]    mul_prod_m;

  logic [1:0]           resp_valid;
  logic [1:0]           resp_ready;
  logic [XLEN-1:0]      resp_result;
  logic [CNTW-1:0]      conflict_cnt;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_funct3, flush,
           mul_prod_m, resp_ready,
    output req_ready, mul_src_a_e, mul_src_b_e, mul_funct3_e, mul_stall_m,
           mul_flush_m, resp_valid, resp_result, conflict_cnt
  );

  // The requesters plus the multiplier datapath.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_funct3, flush,
           mul_prod_m, resp_ready,
    input  req_ready, mul_src_a_e, mul_src_b_e, mul_funct3_e, mul_stall_m,
           mul_flush_m, resp_valid, resp_result, conflict_cnt
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the favoured requester flips only after a contested grant.
module rr_arb2
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  input  logic       advance,
  output req_idx_t   grant,
  output req_idx_t   prio
);

  always_comb begin
    grant = (&eligible) ? prio : req_idx_t'(eligible[1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (advance && (&eligible)) begin
      prio <= ~grant;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one two-stage multiplier between two requesters, tracking the owner of the
// single M-stage operation and returning its result word with a valid/ready handshake.
module mul_arbiter
  import mdu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNTW = 16
) (
  input logic          clk,
  input logic          reset,
  mul_arbiter_if.slave bus
);

  logic            m_valid;
  req_idx_t        m_owner;
  funct3_t         m_funct3;
  logic [CNTW-1:0] conflict;

  logic [1:0] eligible;
  logic       drain;
  logic       slot_free;
  logic       accept;
  logic       conflict_inc;
  req_idx_t   grant;
  req_idx_t   sel;
  req_idx_t   prio_unused;

  assign eligible  = bus.req_valid & ~bus.flush;
  // A flushed owner frees the slot just like a consumed result.
  assign drain     = m_valid & (bus.resp_ready[m_owner] | bus.flush[m_owner]);
  assign slot_free = ~m_valid | drain;
  assign accept    = slot_free & (|eligible);

  // The favoured-requester flop is kept inside the arbiter; only its grant matters here.
  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .advance  (accept),
    .grant    (grant),
    .prio     (prio_unused)
  );

  assign sel              = accept & grant;
  assign bus.req_ready    = accept ? onehot(grant) : 2'b00;
  assign bus.mul_src_a_e  = sel ? bus.req_a1 : bus.req_a0;
  assign bus.mul_src_b_e  = sel ? bus.req_b1 : bus.req_b0;
  assign bus.mul_funct3_e = bus.req_funct3[sel];

  assign bus.mul_stall_m  = m_valid & ~drain;
  // Clear empty M slots so a bubble never carries stale partial products.
  assign bus.mul_flush_m  = ~accept & ~bus.mul_stall_m;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bus.resp_valid  = 2'b00;
    bus.resp_result = bus.mul_prod_m[2*XLEN-1:XLEN];
    if (m_valid) begin
      bus.resp_valid = onehot(m_owner) & ~bus.flush;
    end
    if (m_funct3 == MUL) begin
      bus.resp_result = bus.mul_prod_m[XLEN-1:0];
    end
  end

  // Counted as a conflict: two eligible requesters with room for one, or any waiting on a busy slot.
  assign conflict_inc     = ((&eligible) & slot_free) | ((|eligible) & ~slot_free);
  assign bus.conflict_cnt = conflict;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_owner  <= 1'b0;
      m_funct3 <= MUL;
      conflict <= '0;
    end else begin
      if (accept) begin
        m_valid  <= 1'b1;
        m_owner  <= grant;
        m_funct3 <= bus.req_funct3[grant];
      end else if (drain) begin
        m_valid  <= 1'b0;
      end
      if (conflict_inc && !(&conflict)) begin
        conflict <= conflict + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed vector table, reset corner case, then random traffic
// against a transaction-level reference model; includes a behavioural two-stage multiplier.
module tb_mul_arbiter;
  import mdu_pkg::*;

  localparam int XLEN = 64;
  localparam int CNTW = 4;
  localparam logic [63:0] ONES = '1;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  mul_arbiter_if #(.XLEN(XLEN), .CNTW(CNTW)) bus ();

  mul_arbiter #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] full_prod(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] f3);
    logic [129:0] xa;
    logic [129:0] xb;
    logic [129:0] p;
    xa = (f3 == MULH || f3 == MULHSU) ? {{66{a[63]}}, a} : {66'b0, a};
    xb = (f3 == MULH) ? {{66{b[63]}}, b} : {66'b0, b};
    p  = xa * xb;
    return p[127:0];
  endfunction

  function automatic logic [63:0] result_word(input logic [63:0] a, input logic [63:0] b,
                                              input logic [2:0] f3);
    logic [127:0] p;
    p = full_prod(a, b, f3);
    return (f3 == MUL) ? p[63:0] : p[127:64];
  endfunction

  // Behavioural multiplier: E operands land in the M register unless held or cleared.
  always @(posedge clk) begin
    if (!bus.mul_stall_m) begin
      bus.mul_prod_m <= bus.mul_flush_m ? 128'b0
                      : full_prod(bus.mul_src_a_e, bus.mul_src_b_e, bus.mul_funct3_e);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] b0,
                       input logic [2:0] f0, input logic [63:0] a1, input logic [63:0] b1,
                       input logic [2:0] f1, input logic [1:0] fl, input logic [1:0] rr);
    bus.req_valid     = v;
    bus.req_a0        = a0;
    bus.req_b0        = b0;
    bus.req_funct3[0] = f0;
    bus.req_a1        = a1;
    bus.req_b1        = b1;
    bus.req_funct3[1] = f1;
    bus.flush         = fl;
    bus.resp_ready    = rr;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [63:0] a0, b0, a1, b1;
    logic [2:0]  f0, f1;
    logic [1:0]  fl, rr;
    logic [1:0]  e_ready, e_rvalid;
    logic [63:0] e_res;
    logic        e_stall, e_flushm;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] b0,
                              input logic [2:0] f0, input logic [63:0] a1, input logic [63:0] b1,
                              input logic [2:0] f1, input logic [1:0] fl, input logic [1:0] rr,
                              input logic [1:0] e_ready, input logic [1:0] e_rvalid,
                              input logic [63:0] e_res, input logic e_stall,
                              input logic e_flushm, input int e_cnt);
    vec_t t;
    t.v = v; t.a0 = a0; t.b0 = b0; t.f0 = f0; t.a1 = a1; t.b1 = b1; t.f1 = f1;
    t.fl = fl; t.rr = rr; t.e_ready = e_ready; t.e_rvalid = e_rvalid; t.e_res = e_res;
    t.e_stall = e_stall; t.e_flushm = e_flushm; t.e_cnt = e_cnt;
    return t;
  endfunction

  // Reference model: in-flight results as a queue of {owner, expected word}.
  typedef struct {
    bit          owner;
    logic [63:0] res;
  } flight_t;

  flight_t inflight[$];
  int      m_prio;
  int      m_cnt;

  task automatic random_cycle(input int idx);
    logic [1:0]  v, fl, rr, want, e_ready, e_rvalid;
    logic [63:0] a[2], b[2];
    logic [2:0]  f[2];
    bit          busy, owner, leaving, room, take, winner, e_stall;
    int          n_want;
    flight_t     nf;

    for (int r = 0; r < 2; r++) begin
      case ($urandom_range(0, 5))
        0: a[r] = ONES;
        1: a[r] = 64'h8000_0000_0000_0000;
        default: a[r] = {$urandom, $urandom};
      endcase
      b[r] = ($urandom_range(0, 4) == 0) ? ONES : {$urandom, $urandom};
      f[r] = 3'($urandom_range(0, 3));
    end
    v  = 2'($urandom_range(0, 3));
    fl = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
    rr = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    drive(v, a[0], b[0], f[0], a[1], b[1], f[1], fl, rr);

    busy    = inflight.size() != 0;
    owner   = busy ? inflight[0].owner : 1'b0;
    leaving = busy && (rr[owner] || fl[owner]);
    room    = !busy || leaving;
    want    = v & ~fl;
    n_want  = int'(want[0]) + int'(want[1]);
    winner  = (n_want == 2) ? m_prio[0] : want[1];
    take    = room && n_want > 0;
    e_ready  = take ? (2'b01 << winner) : 2'b00;
    e_rvalid = (busy && !fl[owner]) ? (2'b01 << owner) : 2'b00;
    e_stall  = busy && !leaving;

    @(negedge clk);
    check($sformatf("rnd%0d ready", idx), bus.req_ready, e_ready);
    check($sformatf("rnd%0d resp_valid", idx), bus.resp_valid, e_rvalid);
    if (e_rvalid != 2'b00)
      check($sformatf("rnd%0d result", idx), bus.resp_result, inflight[0].res);
    check($sformatf("rnd%0d stall", idx), bus.mul_stall_m, e_stall);
    check($sformatf("rnd%0d flush_m", idx), bus.mul_flush_m, !take && !e_stall);
    check($sformatf("rnd%0d conflict", idx), bus.conflict_cnt, m_cnt);
    @(posedge clk);

    if (leaving) void'(inflight.pop_front());
    if (take) begin
      nf.owner = winner;
      nf.res   = result_word(a[winner], b[winner], f[winner]);
      inflight.push_back(nf);
      if (n_want == 2) m_prio = winner ? 0 : 1;
    end
    if ((n_want == 2 && room) || (n_want > 0 && !room))
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    drive(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset ready", bus.req_ready, 2'b00);
    check("reset resp_valid", bus.resp_valid, 2'b00);
    check("reset stall", bus.mul_stall_m, 1'b0);
    check("reset flush_m", bus.mul_flush_m, 1'b1);
    check("reset conflict", bus.conflict_cnt, 0);
    @(posedge clk);
    #1;

    // Single request, contention, back-pressure, flush, high words, flushed request.
    tbl.push_back(mk(2'b01, 7, 6, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b00, 2'b01, 42, 0, 1, 0));
    tbl.push_back(mk(2'b11, 2, 3, MUL, 4, 5, MUL, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2, 3, MUL, 4, 5, MUL, 2'b00, 2'b11, 2'b10, 2'b01, 6, 0, 0, 1));
    tbl.push_back(mk(2'b11, 2, 3, MUL, 4, 5, MUL, 2'b00, 2'b11, 2'b01, 2'b10, 20, 0, 0, 2));
    tbl.push_back(mk(2'b11, 2, 3, MUL, 4, 5, MUL, 2'b00, 2'b11, 2'b10, 2'b01, 6, 0, 0, 3));
    tbl.push_back(mk(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b00, 2'b10, 20, 0, 1, 4));
    tbl.push_back(mk(2'b01, 9, 9, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0, 0, 4));
    tbl.push_back(mk(2'b10, 0, 0, MUL, 3, 11, MUL, 2'b00, 2'b10, 2'b00, 2'b01, 81, 1, 0, 4));
    tbl.push_back(mk(2'b10, 0, 0, MUL, 3, 11, MUL, 2'b00, 2'b10, 2'b00, 2'b01, 81, 1, 0, 5));
    tbl.push_back(mk(2'b10, 0, 0, MUL, 3, 11, MUL, 2'b00, 2'b10, 2'b00, 2'b01, 81, 1, 0, 6));
    tbl.push_back(mk(2'b10, 0, 0, MUL, 3, 11, MUL, 2'b00, 2'b11, 2'b10, 2'b01, 81, 0, 0, 7));
    tbl.push_back(mk(2'b01, 5, 5, MUL, 0, 0, MUL, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 0, 7));
    tbl.push_back(mk(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b01, 2'b00, 2'b01, 25, 0, 1, 7));
    tbl.push_back(mk(2'b01, ONES, ONES, MULH, 0, 0, MUL, 2'b00, 2'b11, 2'b01, 2'b00, 0, 0, 0, 7));
    tbl.push_back(mk(2'b10, 0, 0, MUL, ONES, ONES, MULHU, 2'b00, 2'b11, 2'b10, 2'b01, 0, 0, 0, 7));
    tbl.push_back(mk(2'b01, ONES, 2, MULHSU, 0, 0, MUL, 2'b00, 2'b11, 2'b01, 2'b10,
                     64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 7));
    tbl.push_back(mk(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b00, 2'b01, ONES, 0, 1, 7));
    tbl.push_back(mk(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 1, 7));
    tbl.push_back(mk(2'b01, 1, 1, MUL, 0, 0, MUL, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0, 1, 7));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].f0, tbl[i].a1, tbl[i].b1, tbl[i].f1,
            tbl[i].fl, tbl[i].rr);
      @(negedge clk);
      check($sformatf("vec%0d ready", i), bus.req_ready, tbl[i].e_ready);
      check($sformatf("vec%0d resp_valid", i), bus.resp_valid, tbl[i].e_rvalid);
      if (tbl[i].e_rvalid != 2'b00)
        check($sformatf("vec%0d result", i), bus.resp_result, tbl[i].e_res);
      check($sformatf("vec%0d stall", i), bus.mul_stall_m, tbl[i].e_stall);
      check($sformatf("vec%0d flush_m", i), bus.mul_flush_m, tbl[i].e_flushm);
      check($sformatf("vec%0d conflict", i), bus.conflict_cnt, tbl[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-cycle while a result is held in M.
    drive(2'b01, 3, 3, MUL, 0, 0, MUL, 2'b00, 2'b00);
    @(posedge clk);
    #1 drive(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b00);
    #2 check("midreset held valid", bus.resp_valid, 2'b01);
    reset = 1'b1;
    #1;
    check("midreset resp_valid", bus.resp_valid, 2'b00);
    check("midreset conflict", bus.conflict_cnt, 0);
    check("midreset stall", bus.mul_stall_m, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(2'b11, 1, 1, MUL, 2, 2, MUL, 2'b00, 2'b11);
    @(negedge clk);
    check("postreset grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1 drive(2'b00, 0, 0, MUL, 0, 0, MUL, 2'b00, 2'b11);
    @(negedge clk);
    check("postreset resp_valid", bus.resp_valid, 2'b01);
    check("postreset result", bus.resp_result, 1);
    @(posedge clk);

    // Fresh start for the random phase so the model begins from reset state.
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    inflight.delete();
    m_prio = 0;
    m_cnt  = 0;
    for (int n = 0; n < 1500; n++) random_cycle(n);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
